// File: rtl/arr_stim_pkg.sv
// Shared types and constants for the arr_stim stimulus generator.
package arr_stim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [31:0] Poly        = 32'h8020_0003;
  localparam logic [31:0] DefaultSeed = 32'h0000_0001;
  localparam int unsigned DefaultCntW = 16;

  // Right-shift Galois step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? Poly : 32'h0);
  endfunction

endpackage

// File: rtl/arr_stim_if.sv
// Control and vector-pair handshake bundle between arr_stim (master) and its consumer (slave).
interface arr_stim_if #(
  parameter int unsigned LENGTH = 8,
  parameter int unsigned CNT_W  = arr_stim_pkg::DefaultCntW
);
  logic              start;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  inject;
  logic              ready;
  logic              valid;
  logic [LENGTH-1:0] sig0;
  logic [LENGTH-1:0] sig1;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  sent;

  modport master (
    input  start, count, inject, ready,
    output valid, sig0, sig1, busy, done, sent
  );

  modport slave (
    output start, count, inject, ready,
    input  valid, sig0, sig1, busy, done, sent
  );
endinterface

// File: rtl/arr_stim_lfsr.sv
// 32-bit Galois LFSR register; load takes priority over advance.
module arr_stim_lfsr
  import arr_stim_pkg::*;
(
  input  logic        clk_i,
  input  logic        load_i,
  input  logic [31:0] value_i,
  input  logic        advance_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = value_i;
    end else if (advance_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i) begin
    state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/arr_stim.sv
// Burst stimulus generator for the arr checker, with optional single-vector corruption.
// Optional ARR_STIM_BUBBLE_EN: one idle cycle after accepting a vector whose lfsr[31] was set.
module arr_stim
  import arr_stim_pkg::*;
#(
  parameter int unsigned LENGTH = 8,
  parameter logic [31:0] SEED   = DefaultSeed,
  parameter int unsigned CNT_W  = DefaultCntW
) (
  input logic        arr_stim_clk_ip,
  input logic        arr_stim_rst_ip,
  arr_stim_if.master bus
);

  localparam logic [31:0] SeedEff = (SEED == 32'h0) ? 32'h1 : SEED;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   inject_q, inject_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [31:0]        lfsr_q;
  logic               lfsr_load, lfsr_adv;
  logic               valid, busy, done, corrupt;
  logic [LENGTH-1:0]  sig0;
`ifdef ARR_STIM_BUBBLE_EN
  logic               bubble_q, bubble_d;
`endif

  arr_stim_lfsr u_lfsr (
    .clk_i    (arr_stim_clk_ip),
    .load_i   (arr_stim_rst_ip | lfsr_load),
    .value_i  (SeedEff),
    .advance_i(lfsr_adv),
    .state_o  (lfsr_q)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    inject_d  = inject_q;
    sent_d    = sent_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    valid     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
`ifdef ARR_STIM_BUBBLE_EN
    bubble_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          count_d   = bus.count;
          inject_d  = bus.inject;
          sent_d    = '0;
          lfsr_load = 1'b1;
          state_d   = (bus.count == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
`ifdef ARR_STIM_BUBBLE_EN
        valid = ~bubble_q;
`else
        valid = 1'b1;
`endif
        if (valid && bus.ready) begin
          sent_d   = sent_q + CNT_W'(1);
          lfsr_adv = 1'b1;
`ifdef ARR_STIM_BUBBLE_EN
          bubble_d = lfsr_q[31];
`endif
          if (sent_d == count_q) state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge arr_stim_clk_ip) begin
    if (arr_stim_rst_ip) begin
      state_q  <= StIdle;
      count_q  <= '0;
      inject_q <= '0;
      sent_q   <= '0;
`ifdef ARR_STIM_BUBBLE_EN
      bubble_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      inject_q <= inject_d;
      sent_q   <= sent_d;
`ifdef ARR_STIM_BUBBLE_EN
      bubble_q <= bubble_d;
`endif
    end
  end

  // sig0 is the 32-bit LFSR value tiled across the vector width.
  always_comb begin
    sig0 = '0;
    if (valid) begin
      for (int unsigned i = 0; i < LENGTH; i++) sig0[i] = lfsr_q[i % 32];
    end
  end

  assign corrupt = valid && ((sent_q + CNT_W'(1)) == inject_q);

  assign bus.valid = valid;
  assign bus.sig0  = sig0;
  assign bus.sig1  = sig0 ^ LENGTH'(corrupt);
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.sent  = sent_q;

  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q;

endmodule

// File: tb/tb_arr_stim.sv
// Directed scoreboard bench for arr_stim (LENGTH=8 and LENGTH=40 instances).
module tb_arr_stim;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arr_stim_if #(.LENGTH(8),  .CNT_W(16)) b8 ();
  arr_stim_if #(.LENGTH(40), .CNT_W(16)) b40 ();

  arr_stim #(.LENGTH(8), .SEED(32'h1), .CNT_W(16)) dut8 (
    .arr_stim_clk_ip(clk),
    .arr_stim_rst_ip(rst),
    .bus            (b8.master)
  );

  arr_stim #(.LENGTH(40), .SEED(32'h1), .CNT_W(16)) dut40 (
    .arr_stim_clk_ip(clk),
    .arr_stim_rst_ip(rst),
    .bus            (b40.master)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_mis = 0;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // Expected {sig0, sig1} pairs for a burst from seed 1.
  task automatic push_burst(input int count, input int inject);
    logic [31:0] l;
    logic [7:0]  v;
    l = 32'h1;
    for (int i = 1; i <= count; i++) begin
      v = l[7:0];
      sb.push_back({v, (i == inject) ? (v ^ 8'h01) : v});
      l = model_step(l);
    end
  endtask

  // Checks the accept about to happen on the next edge, then advances one cycle.
  task automatic tick(output logic was_valid, output logic was_done);
    logic [15:0] e;
    #2;
    was_valid = b8.valid;
    was_done  = b8.done;
    if (b8.valid === 1'b1 && b8.ready === 1'b1) begin
      if (b8.sig0 !== b8.sig1) n_mis++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("sig0", 64'(b8.sig0), 64'(e[15:8]));
        chk("sig1", 64'(b8.sig1), 64'(e[7:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    logic v, d;
    tick(v, d);
  endtask

  task automatic run_burst(input int max_cyc, output int nv, output int nd);
    logic v, d;
    nv = 0;
    nd = 0;
    for (int i = 0; i < max_cyc; i++) begin
      tick(v, d);
      if (v === 1'b1) nv++;
      if (d === 1'b1) nd++;
      if (nd != 0) break;
    end
  endtask

  task automatic start8(input int count, input int inject);
    b8.start  = 1'b1;
    b8.count  = 16'(count);
    b8.inject = 16'(inject);
    step();
    b8.start  = 1'b0;
  endtask

  int nv, nd;

  initial begin
    b8.start = 0;  b8.count = 0;  b8.inject = 0;  b8.ready = 0;
    b40.start = 0; b40.count = 0; b40.inject = 0; b40.ready = 0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 64'(b8.valid), 64'd0);
    chk("rst_busy",  64'(b8.busy),  64'd0);
    chk("rst_done",  64'(b8.done),  64'd0);
    chk("rst_sent",  64'(b8.sent),  64'd0);
    chk("rst_sig0",  64'(b8.sig0),  64'd0);
    chk("rst_sig1",  64'(b8.sig1),  64'd0);

    // 1: plain burst of 3
    b8.ready = 1'b1;
    push_burst(3, 0);
    start8(3, 0);
    chk("t1_valid_after_start", 64'(b8.valid), 64'd1);
    chk("t1_first_sig0", 64'(b8.sig0), 64'h01);
    run_burst(20, nv, nd);
    chk("t1_valid_cycles", 64'(nv), 64'd3);
    chk("t1_done_pulses",  64'(nd), 64'd1);
    chk("t1_sent",         64'(b8.sent), 64'd3);
    chk("t1_busy_after",   64'(b8.busy), 64'd0);
    chk("t1_done_one_cyc", 64'(b8.done), 64'd0);
    chk("t1_sb_empty",     64'(sb.size()), 64'd0);

    // 2: inject vector 2
    n_mis = 0;
    push_burst(3, 2);
    start8(3, 2);
    run_burst(20, nv, nd);
    chk("t2_valid_cycles", 64'(nv), 64'd3);
    chk("t2_mismatches",   64'(n_mis), 64'd1);
    chk("t2_sent",         64'(b8.sent), 64'd3);
    chk("t2_sb_empty",     64'(sb.size()), 64'd0);

    // 3: backpressure on vector 2
    push_burst(3, 0);
    start8(3, 0);
    step();
    b8.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold_sig0",  64'(b8.sig0),  64'h03);
      chk("t3_hold_sent",  64'(b8.sent),  64'd1);
      chk("t3_hold_valid", 64'(b8.valid), 64'd1);
    end
    b8.ready = 1'b1;
    run_burst(20, nv, nd);
    chk("t3_valid_cycles", 64'(nv), 64'd2);
    chk("t3_done_pulses",  64'(nd), 64'd1);
    chk("t3_sent",         64'(b8.sent), 64'd3);
    chk("t3_sb_empty",     64'(sb.size()), 64'd0);

    // 4: zero-length burst
    start8(0, 0);
    chk("t4_done",   64'(b8.done),  64'd1);
    chk("t4_valid",  64'(b8.valid), 64'd0);
    chk("t4_sent",   64'(b8.sent),  64'd0);
    step();
    chk("t4_done_one_cyc", 64'(b8.done),  64'd0);
    chk("t4_valid_after",  64'(b8.valid), 64'd0);
    chk("t4_busy_after",   64'(b8.busy),  64'd0);

    // 5: reset mid-burst
    push_burst(5, 0);
    start8(5, 0);
    step();
    step();
    chk("t5_sent_before_rst", 64'(b8.sent), 64'd2);
    b8.ready = 1'b0;
    sb.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid", 64'(b8.valid), 64'd0);
    chk("t5_busy",  64'(b8.busy),  64'd0);
    chk("t5_sent",  64'(b8.sent),  64'd0);
    chk("t5_done",  64'(b8.done),  64'd0);
    step();
    chk("t5_no_done_later", 64'(b8.done), 64'd0);
    b8.ready = 1'b1;
    push_burst(1, 0);
    start8(1, 0);
    chk("t5_replay_sig0", 64'(b8.sig0), 64'h01);
    run_burst(20, nv, nd);
    chk("t5_done_pulses", 64'(nd), 64'd1);
    chk("t5_sb_empty",    64'(sb.size()), 64'd0);

    // 6: LENGTH=40 tiling
    b40.start = 1'b1;
    b40.count = 16'd1;
    step();
    b40.start = 1'b0;
    chk("t6_valid", 64'(b40.valid), 64'd1);
    chk("t6_sig0",  64'(b40.sig0),  64'h01_0000_0001);
    chk("t6_sig1",  64'(b40.sig1),  64'h01_0000_0001);
    b40.ready = 1'b1;
    step();
    chk("t6_done", 64'(b40.done), 64'd1);
    chk("t6_sent", 64'(b40.sent), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
